serial_to_parallel_4: RTL and testbench
=======================================

// Module: serial_to_parallel_4
//
// PURPOSE
//  Collects a 1-bit serial stream into WIDTH-bit parallel words, the inverse of our 4-to-1 reduction path.
//  Serial side: valid/ready, one bit per accepted beat, optional s_last frame marker.
//  Parallel side: one-entry output slot with valid/ready, plus an all-ones flag for the gate-level checkers downstream.
//
// PARAMETERS
//  WIDTH      4   bits per parallel word; legal range 2..32
//  MSB_FIRST  1   1: first serial bit -> p_data[WIDTH-1]; 0: first bit -> p_data[0]
//
// PORTS
//  clk         input   1      single clock, rising edge
//  rst_n       input   1      reset, asynchronous assert, active-low
//  s_data      input   1      serial data bit
//  s_valid     input   1      s_data valid
//  s_ready     output  1      block accepts s_data this cycle
//  s_last      input   1      marks final bit of a word; qualified by s_valid&&s_ready
//  p_data      output  WIDTH  assembled word, stable while p_valid=1 and p_ready=0
//  p_valid     output  1      output slot full
//  p_ready     input   1      consumer takes p_data this cycle
//  p_all_ones  output  1      &p_data, valid only when p_valid=1, else 0
//  frame_err   output  1      one-cycle pulse: s_last accepted before bit WIDTH-1
//
// BEHAVIOUR
//  Reset (rst_n=0, async): bit count=0, shift reg=0, p_data=0, p_valid=0, p_all_ones=0, frame_err=0; s_ready=1 after release.
//  Partial word in progress at reset is discarded; no output produced.
//  Beat accepted = s_valid && s_ready at rising clk. Bits are only shifted on accepted beats.
//  Counter cnt: 0..WIDTH-1, $clog2(WIDTH) bits; increments per accepted beat, wraps to 0 after bit WIDTH-1.
//  Word completion: accepted beat with cnt==WIDTH-1 -> p_data loaded with full word (incl. this bit) at that edge,
//   p_valid=1 from the following cycle (latency 1 clk from last-bit edge to p_valid visible); cnt->0.
//  Output slot: EMPTY (p_valid=0) / FULL (p_valid=1). FULL->EMPTY on p_valid&&p_ready with no completion same edge.
//  Backpressure: s_ready = !(p_valid && !p_ready && cnt==WIDTH-1). Bits 0..WIDTH-2 of the next word
//   are accepted while the slot is full; only the completing bit stalls.
//  Simultaneous drain + completion: p_ready=1 and completing beat on same edge -> p_data takes new word,
//   p_valid stays 1 (no bubble, no loss).
//  s_last with cnt==WIDTH-1: normal completion. s_last absent on bit WIDTH-1: still completes (marker optional).
//  s_last with cnt<WIDTH-1: frame_err=1 for exactly the next cycle, partial word dropped, cnt->0,
//   output slot untouched.
//  s_valid=0 or gaps of any length: state held; no timeout.
//  p_data/p_valid change only on clk edges; no combinational path s_* -> p_*. s_ready depends on p_ready combinationally.
//  p_all_ones registered alongside p_data (1-clk aligned with p_valid).
//
// STRUCTURE
//  Shared package ser_par_pkg: localparam WIDTH_DEF=4, function cnt_w(width)=$clog2(width).
//  Single module; no sub-module. Internal: shift register, bit counter, output slot register + valid flag.
//  No FSM enum needed beyond slot EMPTY/FULL flag; counter defines collect progress.
//
// TESTING
//  1. WIDTH=4, MSB_FIRST=1, p_ready=1, bits 1,0,1,1 back-to-back -> p_data=4'b1011, p_valid 1 clk after 4th beat, p_all_ones=0.
//  2. Bits 1,1,1,1 then 0,1,0,1 continuous, p_ready=1 -> words 4'hF (p_all_ones=1) then 4'h5, p_valid never drops between.
//  3. p_ready=0 after word 4'hA, feed 4 more bits -> first 3 accepted, s_ready=0 on 4th, p_data holds 4'hA;
//     raise p_ready -> 4'hA taken, next word completes same or next edge, no bit lost.
//  4. s_last on 2nd bit (cnt=1) -> frame_err pulse 1 clk, no p_valid; next 4 bits 0,0,1,1 -> p_data=4'b0011.
//  5. rst_n low mid-word after 2 bits, and again with p_valid=1 -> all outputs 0 immediately (async); fresh word correct after release.
//  6. MSB_FIRST=0, WIDTH=8, bits 1,0,0,0,0,0,0,0 -> p_data=8'h01; random s_valid gaps vs. scoreboard, 1000 words.

Source files
------------

// File: rtl/ser_par_pkg.sv
// Shared constants and helpers for the serial-to-parallel collector.
// Imported by serial_to_parallel_4.
package ser_par_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_to_parallel_4.sv
// Collects a valid/ready 1-bit serial stream into WIDTH-bit words.
// One-entry output slot with valid/ready and a registered all-ones flag.
module serial_to_parallel_4
    import ser_par_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             p_all_ones,
    output logic             frame_err
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_to_parallel_4: WIDTH out of range");
    end

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_next;
    logic             last_bit;
    logic             beat;
    logic             complete;
    logic             early_last;
    logic             drain;

    assign last_bit   = (cnt == CNT_LAST);
    // Only the completing bit has to wait for a full, undrained slot.
    assign s_ready    = !(p_valid && !p_ready && last_bit);
    assign beat       = s_valid && s_ready;
    assign complete   = beat && last_bit;
    assign early_last = beat && s_last && !last_bit;
    assign drain      = p_valid && p_ready;

    always_comb begin
        word_next = shreg;
        if (MSB_FIRST) begin
            word_next = {shreg[WIDTH-2:0], s_data};
        end else begin
            word_next = {s_data, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (beat) begin
            if (last_bit || s_last) begin
                cnt   <= '0;
                shreg <= '0;
            end else begin
                cnt   <= cnt + CNT_ONE;
                shreg <= word_next;
            end
        end
    end

    // Completion wins over drain so a same-edge handoff leaves no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data     <= '0;
            p_valid    <= 1'b0;
            p_all_ones <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= early_last;
            if (complete) begin
                p_data     <= word_next;
                p_valid    <= 1'b1;
                p_all_ones <= &word_next;
            end else if (drain) begin
                p_valid    <= 1'b0;
                p_all_ones <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_4.sv
// Directed, table-driven and scoreboard checks for serial_to_parallel_4.
// Covers WIDTH=4 MSB-first and WIDTH=8 LSB-first instances.
module tb_serial_to_parallel_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_data, s_valid, s_last, s_ready;
    logic [3:0] p_data;
    logic       p_valid, p_ready, p_all_ones, frame_err;

    logic       b_data, b_valid, b_last, b_ready;
    logic [7:0] q_data;
    logic       q_valid, q_ready, q_all_ones, b_frame_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] seq;
        logic       last3;
        logic [3:0] exp;
        logic       ones;
    } vec_t;

    vec_t tbl[7];
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    serial_to_parallel_4 #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
        .p_all_ones(p_all_ones), .frame_err(frame_err)
    );

    serial_to_parallel_4 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready), .s_last(b_last),
        .p_data(q_data), .p_valid(q_valid), .p_ready(q_ready),
        .p_all_ones(q_all_ones), .frame_err(b_frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic d, input logic last);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        #1;
        while (!s_ready && guard < 50) begin
            tick();
            #1;
            guard++;
        end
        if (!s_ready) chk("send_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] seq, input logic last3);
        for (int j = 0; j < 4; j++) send_bit(seq[j], last3 && j == 3);
    endtask

    initial begin
        tbl[0] = '{seq: 4'b1101, last3: 1'b0, exp: 4'b1011, ones: 1'b0};
        tbl[1] = '{seq: 4'b1111, last3: 1'b1, exp: 4'b1111, ones: 1'b1};
        tbl[2] = '{seq: 4'b1010, last3: 1'b0, exp: 4'b0101, ones: 1'b0};
        tbl[3] = '{seq: 4'b0001, last3: 1'b1, exp: 4'b1000, ones: 1'b0};
        tbl[4] = '{seq: 4'b0110, last3: 1'b0, exp: 4'b0110, ones: 1'b0};
        tbl[5] = '{seq: 4'b1000, last3: 1'b0, exp: 4'b0001, ones: 1'b0};
        tbl[6] = '{seq: 4'b0000, last3: 1'b1, exp: 4'b0000, ones: 1'b0};

        rst_n = 1'b0;
        {s_data, s_valid, s_last, p_ready} = '0;
        {b_data, b_valid, b_last} = '0;
        q_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_p_valid", 32'(p_valid), 32'd0);
        chk("rst_p_data", 32'(p_data), 32'd0);
        chk("rst_all_ones", 32'(p_all_ones), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst8_p_valid", 32'(q_valid), 32'd0);
        @(negedge clk);

        // first word: valid exactly one clock after the 4th beat
        p_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("t1_not_yet_valid", 32'(p_valid), 32'd0);
        send_bit(1'b1, 1'b0);
        chk("t1_valid", 32'(p_valid), 32'd1);
        chk("t1_data", 32'(p_data), 32'hB);
        chk("t1_ones", 32'(p_all_ones), 32'd0);
        tick();
        chk("t1_drained", 32'(p_valid), 32'd0);
        chk("t1_ones_clr", 32'(p_all_ones), 32'd0);

        // table: back-to-back words, p_ready=1
        for (int i = 0; i < 7; i++) begin
            send_word(tbl[i].seq, tbl[i].last3);
            chk($sformatf("tbl%0d_valid", i), 32'(p_valid), 32'd1);
            chk($sformatf("tbl%0d_data", i), 32'(p_data), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_ones", i), 32'(p_all_ones), 32'(tbl[i].ones));
            chk($sformatf("tbl%0d_ferr", i), 32'(frame_err), 32'd0);
        end
        tick();

        // backpressure and same-edge drain + completion
        p_ready = 1'b0;
        send_word(4'b0101, 1'b0);
        chk("t3_data_a", 32'(p_data), 32'hA);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("t3_hold_data", 32'(p_data), 32'hA);
        chk("t3_hold_valid", 32'(p_valid), 32'd1);
        s_valid = 1'b1;
        s_data  = 1'b0;
        #1;
        chk("t3_stall", 32'(s_ready), 32'd0);
        tick();
        chk("t3_still_a", 32'(p_data), 32'hA);
        p_ready = 1'b1;
        #1;
        chk("t3_unstall", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        chk("t3_next_data", 32'(p_data), 32'hC);
        chk("t3_no_bubble", 32'(p_valid), 32'd1);
        tick();
        chk("t3_drained", 32'(p_valid), 32'd0);

        // early s_last
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("t4_ferr", 32'(frame_err), 32'd1);
        chk("t4_no_valid", 32'(p_valid), 32'd0);
        tick();
        chk("t4_ferr_pulse", 32'(frame_err), 32'd0);
        send_word(4'b1100, 1'b0);
        chk("t4_data", 32'(p_data), 32'h3);
        chk("t4_valid", 32'(p_valid), 32'd1);
        tick();

        // async reset mid-word
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5a_valid", 32'(p_valid), 32'd0);
        chk("t5a_data", 32'(p_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(4'b0110, 1'b0);
        chk("t5a_fresh", 32'(p_data), 32'h6);
        tick();

        // async reset with slot full
        p_ready = 1'b0;
        send_word(4'b1111, 1'b0);
        chk("t5b_pre_ones", 32'(p_all_ones), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5b_valid", 32'(p_valid), 32'd0);
        chk("t5b_data", 32'(p_data), 32'd0);
        chk("t5b_ones", 32'(p_all_ones), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        p_ready = 1'b1;
        #1;
        chk("t5b_s_ready", 32'(s_ready), 32'd1);
        send_word(4'b1001, 1'b0);
        chk("t5b_fresh", 32'(p_data), 32'h9);
        tick();

        // LSB-first, WIDTH=8
        q_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            b_valid = 1'b1;
            b_data  = (j == 0);
            tick();
        end
        b_valid = 1'b0;
        chk("t6_valid", 32'(q_valid), 32'd1);
        chk("t6_data", 32'(q_data), 32'h01);
        q_ready = 1'b1;
        tick();

        // random gaps and backpressure vs scoreboard
        fork
            begin
                for (int w = 0; w < 1000; w++) begin
                    logic [7:0] word;
                    word = 8'($urandom);
                    sb_q.push_back(word);
                    for (int j = 0; j < 8; j++) begin
                        int guard;
                        logic acc;
                        repeat ($urandom_range(0, 2)) begin
                            b_valid = 1'b0;
                            @(negedge clk);
                        end
                        b_valid = 1'b1;
                        b_data  = word[j];
                        guard = 0;
                        do begin
                            #1;
                            acc = b_ready;
                            @(negedge clk);
                            guard++;
                        end while (!acc && guard < 100);
                    end
                end
                b_valid = 1'b0;
            end
            begin
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < 1000 && cyc < 50000) begin
                    @(negedge clk);
                    cyc++;
                    q_ready = 1'($urandom_range(0, 1));
                    if (q_valid && q_ready) begin
                        if (sb_q.size() == 0) begin
                            chk("rand_underflow", 32'd1, 32'd0);
                        end else begin
                            logic [7:0] e;
                            e = sb_q.pop_front();
                            chk("rand_word", 32'(q_data), 32'(e));
                            chk("rand_ones", 32'(q_all_ones), 32'(&e));
                        end
                        got++;
                    end
                end
                chk("rand_count", 32'(got), 32'd1000);
                chk("rand_ferr", 32'(b_frame_err), 32'd0);
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
